// File: rtl/ad9764_tx_pkg.sv
// Shared types and constants for the AD9764 dual-DAC transmit path.
package ad9764_tx_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAKE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Offset-binary zero: MSB set, all other bits clear.
    function automatic logic [31:0] midscale(input int unsigned d_bit);
        return 32'd1 << (d_bit - 1);
    endfunction

endpackage

// File: rtl/dac_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata shows the head word whenever not empty.
module dac_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = cnt_q;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ad9764_tx.sv
// AD9764 transmit sequencer: power-up/prime/run/drain FSM over a sample FIFO.
// Define AD9764_UF_CNT_EN to add the saturating 16-bit underflow counter port oUF_CNT.
module ad9764_tx import ad9764_tx_pkg::*; #(
    parameter int CH_NUM     = 2,
    parameter int D_BIT      = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int WAKE_DELAY = 8,
    parameter int PRIME_LVL  = 8
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iEN,
    input  logic [CH_NUM*D_BIT-1:0]     iDATA,
    input  logic                        iVALID,
    output logic                        oREADY,
    output logic [CH_NUM-1:0]           oDAC_CLK,
    output logic [CH_NUM*D_BIT-1:0]     oDAC_DATA,
    output logic [CH_NUM-1:0]           oSLEEP,
    output logic                        oRUN,
    output logic                        oUNDERFLOW,
    output logic [$clog2(FIFO_DEPTH):0] oLEVEL
`ifdef AD9764_UF_CNT_EN
    ,
    output logic [15:0]                 oUF_CNT
`endif
);
    localparam int DW    = CH_NUM * D_BIT;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(WAKE_DELAY + 1) + 1;
    localparam logic [D_BIT-1:0] MID_CH   = D_BIT'(midscale(D_BIT));
    localparam logic [DW-1:0]    MID_WORD = {CH_NUM{MID_CH}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      dac_q, dac_d;
    logic [CH_NUM-1:0]  sleep_q, sleep_d;
    logic               run_q, run_d;
    logic               uf_q, uf_d;

    logic               fifo_push, fifo_pop, fifo_flush;
    logic               fifo_empty, fifo_full;
    logic [DW-1:0]      fifo_rdata;
    logic [LVL_W-1:0]   fifo_level;

    dac_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCLK),
        .rst   (iRST),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (iDATA),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign oREADY    = !fifo_full && (state_q inside {ST_WAKE, ST_PRIME, ST_RUN});
    assign fifo_push = iVALID && oREADY;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dac_d      = dac_q;
        uf_d       = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_OFF: begin
                dac_d = MID_WORD;
                if (iEN) begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_W'(WAKE_DELAY);
                end
            end
            ST_WAKE: begin
                if (!iEN) begin
                    state_d    = ST_OFF;
                    cnt_d      = '0;
                    fifo_flush = 1'b1;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_PRIME;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PRIME: begin
                dac_d = MID_WORD;
                if (!iEN) begin
                    state_d = ST_DRAIN;
                end else if (fifo_level >= LVL_W'(PRIME_LVL)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Disable still consumes this cycle's word so every non-midscale cycle is one sample.
                if (!iEN) begin
                    state_d = ST_DRAIN;
                    if (fifo_empty) begin
                        dac_d = MID_WORD;
                    end else begin
                        fifo_pop = 1'b1;
                        dac_d    = fifo_rdata ^ MID_WORD;
                    end
                end else if (fifo_empty) begin
                    state_d = ST_PRIME;
                    dac_d   = MID_WORD;
                    uf_d    = 1'b1;
                end else begin
                    fifo_pop = 1'b1;
                    dac_d    = fifo_rdata ^ MID_WORD;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_OFF;
                    dac_d   = MID_WORD;
                end else begin
                    fifo_pop = 1'b1;
                    dac_d    = fifo_rdata ^ MID_WORD;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
                dac_d   = MID_WORD;
            end
        endcase
        sleep_d = (state_d == ST_OFF) ? '1 : '0;
        run_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            dac_q   <= MID_WORD;
            sleep_q <= '1;
            run_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dac_q   <= dac_d;
            sleep_q <= sleep_d;
            run_q   <= run_d;
            uf_q    <= uf_d;
        end
    end

    // Inverted clock gives the DAC half a cycle of setup on the registered data.
    assign oDAC_CLK   = {CH_NUM{~iCLK}};
    assign oDAC_DATA  = dac_q;
    assign oSLEEP     = sleep_q;
    assign oRUN       = run_q;
    assign oUNDERFLOW = uf_q;
    assign oLEVEL     = fifo_level;

`ifdef AD9764_UF_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (uf_d && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign oUF_CNT = uf_cnt_q;
`endif

endmodule
